// File: rtl/matrix_glyph_streamer_pkg.sv
// Shared constants, types, font table and pixel-order helper for the glyph streamer.
package matrix_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam logic [5:0] LAST_PIX = 6'(ROWS * COLS - 1);

   typedef logic [4:0] glyph_code_t;

   localparam glyph_code_t GLYPH_SPACE = 5'd26;

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, NEXT} state_t;

   // Byte 7 is the top row; the MSB of each byte is the leftmost column.
   localparam logic [63:0] FONT_ROM [27] = '{
      64'h0000780c7ccc7600,  // a
      64'he060607c6666dc00,  // b
      64'h000078ccc0cc7800,  // c
      64'h1c0c0c7ccccc7600,  // d
      64'h000078ccfcc07800,  // e
      64'h386c60f06060f000,  // f
      64'h000076cccc7c0cf8,  // g
      64'he0606c766666e600,  // h
      64'h3000703030307800,  // i
      64'h0c000c0c0ccccc78,  // j
      64'he060666c786ce600,  // k
      64'h7030303030307800,  // l
      64'h0000ccfefed6c600,  // m
      64'h0000f8cccccccc00,  // n
      64'h000078cccccc7800,  // o
      64'h0000dc66667c60f0,  // p
      64'h000076cccc7c0c1e,  // q
      64'h0000dc766660f000,  // r
      64'h00007cc0780cf800,  // s
      64'h10307c3030341800,  // t
      64'h0000cccccccc7600,  // u
      64'h0000cccccc783000,  // v
      64'h0000c6d6fefe6c00,  // w
      64'h0000c66c386cc600,  // x
      64'h0000cccccc7c0cf8,  // y
      64'h0000fc983064fc00,  // z
      64'h0000000000000000   // space
   };

   // Strip order is serpentine: even rows run right-to-left, odd rows left-to-right.
   function automatic logic pixel_bit(input logic [63:0] word, input logic [5:0] p);
      logic [2:0] r;
      logic [2:0] c;
      logic [5:0] zz;
      r  = p[5:3];
      c  = p[2:0];
      zz = r[0] ? {r, c} : {r, ~c};
      return word[6'd63 - zz];
   endfunction

endpackage

// File: rtl/matrix_glyph_streamer_font_rom.sv
// Combinational 8x8 font lookup; any code past the last glyph maps to the blank word.
module matrix_font_rom
   import matrix_pkg::*;
(
   input  logic [4:0]  code,
   output logic [63:0] glyph_word
);

   // Table lookup with a blank fallback for out-of-range codes.
   always_comb begin
      glyph_word = FONT_ROM[GLYPH_SPACE];
      if (code < GLYPH_SPACE) begin
         glyph_word = FONT_ROM[code];
      end
   end

endmodule

// File: rtl/matrix_glyph_streamer.sv
// Holds a short glyph message and streams each glyph's 64 LED bits in strip order
// over a valid/ready handshake, looping over the message indefinitely.
module matrix_glyph_streamer
   import matrix_pkg::*;
#(
   parameter int MSG_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [4:0]                   wr_char,
   input  logic                         msg_clear,
   input  logic                         pix_ready,
   output logic                         pix_valid,
   output logic                         pix_on,
   output logic                         pix_last,
   output logic                         glyph_first,
   output logic [$clog2(MSG_DEPTH):0]   msg_len,
   output logic                         overflow
);

   localparam int AW = $clog2(MSG_DEPTH);
   localparam int LW = AW + 1;

   glyph_code_t       msg_mem [MSG_DEPTH];
   glyph_code_t       rd_code_reg;
   logic [LW-1:0]     msg_len_reg;
   logic              overflow_reg;
   logic [AW-1:0]     char_idx_reg;
   state_t            state_reg;
   logic [5:0]        pix_cnt_reg;
   logic [63:0]       glyph_word_reg;
   logic              pix_valid_reg;
   logic              pix_on_reg;
   logic              pix_last_reg;
   logic              glyph_first_reg;

   logic              full;
   logic              wr_accept;
   logic [AW-1:0]     wr_addr;
   glyph_code_t       wr_code;
   logic [AW-1:0]     next_idx;
   logic [AW-1:0]     rd_addr;
   logic              transfer;
   logic [63:0]       rom_word;

   // Write path, wrap-around index and read address; a clear redirects the write to entry 0.
   always_comb begin
      full      = (msg_len_reg == LW'(MSG_DEPTH));
      wr_accept = wr_en && (msg_clear || !full);
      wr_addr   = msg_clear ? '0 : msg_len_reg[AW-1:0];
      wr_code   = (wr_char > GLYPH_SPACE) ? GLYPH_SPACE : wr_char;
      next_idx  = ((LW'(char_idx_reg) + LW'(1)) == msg_len_reg) ? '0 : char_idx_reg + AW'(1);
      rd_addr   = (state_reg == NEXT) ? next_idx : char_idx_reg;
      transfer  = pix_valid_reg && pix_ready;
   end

   // Message buffer with a registered read port; NEXT prefetches the following entry for LOAD.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         msg_mem[wr_addr] <= wr_code;
      end
      rd_code_reg <= msg_mem[rd_addr];
   end

   matrix_font_rom u_font_rom (
      .code       (rd_code_reg),
      .glyph_word (rom_word)
   );

   // Stored length and sticky overflow; clear takes priority and may admit one write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_len_reg  <= '0;
         overflow_reg <= 1'b0;
      end else if (msg_clear) begin
         msg_len_reg  <= wr_en ? LW'(1) : '0;
         overflow_reg <= 1'b0;
      end else if (wr_en) begin
         if (full) begin
            overflow_reg <= 1'b1;
         end else begin
            msg_len_reg <= msg_len_reg + LW'(1);
         end
      end
   end

   // Streaming FSM with registered pixel outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         char_idx_reg    <= '0;
         pix_cnt_reg     <= '0;
         glyph_word_reg  <= '0;
         pix_valid_reg   <= 1'b0;
         pix_on_reg      <= 1'b0;
         pix_last_reg    <= 1'b0;
         glyph_first_reg <= 1'b0;
      end else if (msg_clear) begin
         state_reg       <= IDLE;
         char_idx_reg    <= '0;
         pix_cnt_reg     <= '0;
         pix_valid_reg   <= 1'b0;
         pix_on_reg      <= 1'b0;
         pix_last_reg    <= 1'b0;
         glyph_first_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (msg_len_reg != '0) begin
                  state_reg <= LOAD;
               end
            end
            LOAD: begin
               glyph_word_reg  <= rom_word;
               pix_cnt_reg     <= '0;
               pix_valid_reg   <= 1'b1;
               pix_on_reg      <= pixel_bit(rom_word, 6'd0);
               glyph_first_reg <= 1'b1;
               pix_last_reg    <= 1'b0;
               state_reg       <= STREAM;
            end
            STREAM: begin
               if (transfer) begin
                  glyph_first_reg <= 1'b0;
                  if (pix_cnt_reg == LAST_PIX) begin
                     pix_valid_reg <= 1'b0;
                     pix_on_reg    <= 1'b0;
                     pix_last_reg  <= 1'b0;
                     state_reg     <= NEXT;
                  end else begin
                     pix_cnt_reg  <= pix_cnt_reg + 6'd1;
                     pix_on_reg   <= pixel_bit(glyph_word_reg, pix_cnt_reg + 6'd1);
                     pix_last_reg <= (pix_cnt_reg == LAST_PIX - 6'd1);
                  end
               end
            end
            NEXT: begin
               char_idx_reg <= next_idx;
               state_reg    <= LOAD;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign pix_valid   = pix_valid_reg;
   assign pix_on      = pix_on_reg;
   assign pix_last    = pix_last_reg;
   assign glyph_first = glyph_first_reg;
   assign msg_len     = msg_len_reg;
   assign overflow    = overflow_reg;

endmodule
